vga_line_prefetch: RTL and testbench
====================================

Name: vga_line_prefetch

Overview:
- Parametrised single-clock successor to the video cache.
- Wishbone B3 classic read master that streams a frame from VRAM into an internal first-word-fall-through FIFO.
- Unpacks 32-bit words into BPP-wide pixels for a same-clock pixel consumer.
- Adds watermark-based refill, retry handling, error reporting, underrun detection and per-frame restart.

Parameters:
- H_WORDS, 160: 32-bit words per scan line.
- V_LINES, 480: lines per frame.
- FIFO_DEPTH, 64: FIFO depth in words; power of two, at least 4.
- LOW_WM, 16: refill resumes when FIFO count <= LOW_WM; must be < FIFO_DEPTH.
- BPP, 8: bits per pixel, 8 or 16; PPW = 32/BPP pixels per word.
- MAX_RETRY, 3: consecutive rty_i terminations tolerated per word before error.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- base_adr_i  in  32  frame base byte address; sampled on frame_start_i.
- frame_start_i  in  1  one-cycle pulse that restarts the frame.
- pix_rd_i  in  1  consumer takes the current pixel this cycle.
- pix_o  out  BPP  current pixel (FWFT); 0 when FIFO empty.
- pix_valid_o  out  1  FIFO not empty.
- underrun_o  out  1  sticky: pix_rd_i arrived while empty.
- err_o  out  1  sticky: err_i received or retry limit exceeded.
- wb_cyc_o, wb_stb_o  out  1 each  bus cycle and strobe.
- wb_adr_o  out  32  base + word_idx*4.
- wb_we_o  out  1  constant 0.
- wb_sel_o  out  4  constant 4'hF.
- wb_dat_o  out  32  constant 0.
- wb_ack_i, wb_err_i, wb_rty_i  in  1 each  slave terminations.
- wb_dat_i  in  32  read data.

Behaviour:
- Reset state: IDLE, word_idx=0, FIFO empty, retry_cnt=0. Outputs cyc/stb/underrun/err/pix_valid = 0, pix_o = 0.
- States:
  - IDLE: waits for frame_start_i.
  - FETCH: cyc=stb=1, held until a termination.
  - PAUSE: cyc=stb=0, FIFO full or above watermark.
  - DONE: all H_WORDS*V_LINES words fetched.
  - ERR: bus halted.
- frame_start_i, in any state:
  - Takes priority over all other events in the same cycle.
  - Flushes the FIFO and the pixel index, sets word_idx=0, latches base_adr_i, clears underrun_o, err_o and retry_cnt.
  - Next state is FETCH.
  - A cycle in flight is aborted by dropping cyc/stb on that edge; any ack in that cycle is discarded.
- FETCH, ack_i:
  - Push wb_dat_i and increment word_idx.
  - Set retry_cnt=0.
  - If word_idx becomes H_WORDS*V_LINES, go to DONE.
  - Else if count after the push == FIFO_DEPTH, go to PAUSE (stb drops on the same edge).
- FETCH, rty_i: no push; keep the same address; retry_cnt++. When retry_cnt would exceed MAX_RETRY, go to ERR and set err_o.
- FETCH, err_i: go to ERR and set err_o. No push.
- Simultaneous terminations: priority err_i > rty_i > ack_i.
- PAUSE -> FETCH when count <= LOW_WM.
- Terminations are honoured only while stb_o=1; terminations in any other state are ignored.
- Invariant: the FIFO never exceeds FIFO_DEPTH, and stb_o=1 implies count < FIFO_DEPTH.
- Address arithmetic: 32-bit, wraps modulo 2^32. word_idx is wide enough for H_WORDS*V_LINES.
- Pixel unpack:
  - pix_o = head word bits [pix_idx*BPP +: BPP], lowest pixel first.
  - On pix_rd_i while valid, pix_idx++. At pix_idx==PPW-1 the word is popped and pix_idx resets to 0.
  - pix_rd_i while empty: sets underrun_o, no pop, pix_o stays 0.
- Simultaneous push and pop: count unchanged. A push into an empty FIFO makes data visible on pix_o the next cycle.
- Latencies: frame_start_i to stb_o = 1 cycle; ack to pix_valid_o = 1 cycle.

Decomposition:
- Package vga_prefetch_pkg:
  - state enum {IDLE, FETCH, PAUSE, DONE, ERR}.
  - WB_SEL_ALL = 4'hF.
  - PPW derivation function.
  - clog2-based width helpers.
- Sub-module sync_fifo_fwft (parametrised WIDTH, DEPTH):
  - ports push, pop, flush, din, dout, count, empty, full.
  - asynchronous active-high reset on the same clock and reset.

Test Plan:
- Reset mid-fetch (wb_rst_i asserted with stb high) -> cyc/stb drop immediately, pix_valid_o=0; after release, IDLE until frame_start_i.
- H_WORDS=4, V_LINES=2, zero-wait ack slave, base=0x1000 -> addresses 0x1000..0x101C in order, then DONE with cyc=0; BPP=8 yields pixels in byte order 0,1,2,3 of each word.
- FIFO_DEPTH=8, LOW_WM=2, no pix_rd_i -> exactly 8 acks then stb drops; after 6 words are popped (count=2), stb re-asserts the next cycle.
- Slave returns rty_i 3 times then ack -> same address 4 times, no error; with 4 rty_i -> ERR, err_o=1, cyc=0.
- pix_rd_i asserted with FIFO empty -> underrun_o=1 and stays set; frame_start_i clears it and the refetch starts at the new base.
- frame_start_i coinciding with ack mid-frame -> acked data discarded, FIFO empty next cycle, next address = new base.

Source files
------------

// File: rtl/vga_line_prefetch_pkg.sv
// Shared types and width helpers for the VGA line prefetcher.
package vga_prefetch_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      PAUSE = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } state_e;

   localparam logic [3:0] WB_SEL_ALL = 4'hF;

   function automatic int ppw_of(input int bpp);
      return 32 / bpp;
   endfunction

   // Index width for n distinct values, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a counter that must hold the value n itself.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/vga_line_prefetch_fifo.sv
// First-word-fall-through word FIFO; dout shows the head entry whenever count > 0.
module sync_fifo_fwft
   import vga_prefetch_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [cnt_w(DEPTH)-1:0]    count,
   output logic                       empty,
   output logic                       full
);

   localparam int AW = idx_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (!do_push && do_pop)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/vga_line_prefetch.sv
// Wishbone classic read master streaming a frame from VRAM into a FWFT FIFO,
// unpacked into BPP-wide pixels for a same-clock consumer.
//
// state | meaning
// IDLE  | waiting for frame_start_i
// FETCH | cyc/stb asserted, waiting for ack/rty/err
// PAUSE | bus idle, FIFO above low watermark
// DONE  | whole frame fetched
// ERR   | bus halted after err_i or retry exhaustion
module vga_line_prefetch
   import vga_prefetch_pkg::*;
#(
   parameter int H_WORDS    = 160,
   parameter int V_LINES    = 480,
   parameter int FIFO_DEPTH = 64,
   parameter int LOW_WM     = 16,
   parameter int BPP        = 8,
   parameter int MAX_RETRY  = 3
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic [31:0]     base_adr_i,
   input  logic            frame_start_i,
   input  logic            pix_rd_i,
   output logic [BPP-1:0]  pix_o,
   output logic            pix_valid_o,
   output logic            underrun_o,
   output logic            err_o,
   output logic            wb_cyc_o,
   output logic            wb_stb_o,
   output logic [31:0]     wb_adr_o,
   output logic            wb_we_o,
   output logic [3:0]      wb_sel_o,
   output logic [31:0]     wb_dat_o,
   input  logic            wb_ack_i,
   input  logic            wb_err_i,
   input  logic            wb_rty_i,
   input  logic [31:0]     wb_dat_i
);

   localparam int PPW    = ppw_of(BPP);
   localparam int TOTAL  = H_WORDS * V_LINES;
   localparam int WIDX_W = cnt_w(TOTAL);
   localparam int CNT_W  = cnt_w(FIFO_DEPTH);
   localparam int PIX_W  = idx_w(PPW);
   localparam int RTY_W  = idx_w(MAX_RETRY + 1);

   localparam logic [2:0] S_IDLE  = IDLE;
   localparam logic [2:0] S_FETCH = FETCH;
   localparam logic [2:0] S_PAUSE = PAUSE;
   localparam logic [2:0] S_DONE  = DONE;
   localparam logic [2:0] S_ERR   = ERR;

   logic [2:0]        state;
   logic [WIDX_W-1:0] word_idx;
   logic [31:0]       base;
   logic [RTY_W-1:0]  retry_cnt;
   logic [PIX_W-1:0]  pix_idx;

   logic [31:0]       head;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  cnt_after;
   logic              empty;
   logic              full;
   logic              take_err;
   logic              take_rty;
   logic              take_ack;
   logic              push;
   logic              pop;
   logic              last_pix;

   assign wb_stb_o = (state == S_FETCH);
   assign wb_cyc_o = wb_stb_o;
   assign wb_adr_o = base + (32'(word_idx) << 2);
   assign wb_we_o  = 1'b0;
   assign wb_sel_o = WB_SEL_ALL;
   assign wb_dat_o = '0;

   assign take_err = wb_stb_o && wb_err_i;
   assign take_rty = wb_stb_o && !wb_err_i && wb_rty_i;
   assign take_ack = wb_stb_o && !wb_err_i && !wb_rty_i && wb_ack_i;

   assign push      = take_ack && !full;
   assign last_pix  = (pix_idx == PIX_W'(PPW - 1));
   assign pop       = pix_rd_i && !empty && last_pix;
   assign cnt_after = count + CNT_W'(1) - CNT_W'(pop);

   assign pix_valid_o = !empty;

   always_comb begin
      pix_o = '0;
      if (!empty) pix_o = head[pix_idx*BPP +: BPP];
   end

   // frame_start_i flushes the FIFO, so an ack landing on the same edge is dropped.
   sync_fifo_fwft #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .push  (push),
      .pop   (pop),
      .flush (frame_start_i),
      .din   (wb_dat_i),
      .dout  (head),
      .count (count),
      .empty (empty),
      .full  (full)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state      <= S_IDLE;
         word_idx   <= '0;
         base       <= '0;
         retry_cnt  <= '0;
         pix_idx    <= '0;
         underrun_o <= 1'b0;
         err_o      <= 1'b0;
      end else if (frame_start_i) begin
         state      <= S_FETCH;
         word_idx   <= '0;
         base       <= base_adr_i;
         retry_cnt  <= '0;
         pix_idx    <= '0;
         underrun_o <= 1'b0;
         err_o      <= 1'b0;
      end else begin
         if (pix_rd_i && empty) underrun_o <= 1'b1;
         if (pix_rd_i && !empty) pix_idx <= last_pix ? '0 : pix_idx + 1'b1;

         case (state)
            S_FETCH: begin
               if (take_err) begin
                  state <= S_ERR;
                  err_o <= 1'b1;
               end else if (take_rty) begin
                  if (retry_cnt == RTY_W'(MAX_RETRY)) begin
                     state <= S_ERR;
                     err_o <= 1'b1;
                  end else begin
                     retry_cnt <= retry_cnt + 1'b1;
                  end
               end else if (take_ack) begin
                  word_idx  <= word_idx + 1'b1;
                  retry_cnt <= '0;
                  if (word_idx == WIDX_W'(TOTAL - 1))
                     state <= S_DONE;
                  else if (cnt_after == CNT_W'(FIFO_DEPTH))
                     state <= S_PAUSE;
               end
            end
            S_PAUSE: begin
               if (count <= CNT_W'(LOW_WM)) state <= S_FETCH;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_line_prefetch.sv
// Directed bench for vga_line_prefetch with a combinational Wishbone slave model.
module tb_vga_line_prefetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] base_adr = '0;
   logic        frame_start = 1'b0;
   logic        pix_rd = 1'b0;
   logic [7:0]  pix;
   logic        pix_valid, underrun, err;
   logic        cyc, stb, we;
   logic [31:0] adr, dat_o, dat_i;
   logic [3:0]  sel;
   logic        ack, berr, rty;
   logic        ack_en = 1'b0, rty_en = 1'b0, err_en = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Slave: data byte k of a word is the low address byte plus k.
   assign ack   = stb & ack_en;
   assign rty   = stb & rty_en;
   assign berr  = stb & err_en;
   assign dat_i = {adr[7:0] + 8'd3, adr[7:0] + 8'd2, adr[7:0] + 8'd1, adr[7:0]};

   vga_line_prefetch #(
      .H_WORDS(4), .V_LINES(4), .FIFO_DEPTH(8), .LOW_WM(2), .BPP(8), .MAX_RETRY(3)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .base_adr_i(base_adr), .frame_start_i(frame_start),
      .pix_rd_i(pix_rd), .pix_o(pix), .pix_valid_o(pix_valid), .underrun_o(underrun),
      .err_o(err), .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_adr_o(adr), .wb_we_o(we),
      .wb_sel_o(sel), .wb_dat_o(dat_o), .wb_ack_i(ack), .wb_err_i(berr), .wb_rty_i(rty),
      .wb_dat_i(dat_i)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [31:0] b);
      base_adr    = b;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if ({cyc, stb, pix_valid, underrun, err} !== 5'b0) begin errors++; $display("FAIL reset_flags got cyc=%b stb=%b valid=%b und=%b err=%b want all 0", cyc, stb, pix_valid, underrun, err); end
      checks++; if (pix !== 8'h00) begin errors++; $display("FAIL reset_pix got %h want 00", pix); end
      checks++; if (we !== 1'b0 || sel !== 4'hF || dat_o !== 32'h0) begin errors++; $display("FAIL reset_consts got we=%b sel=%h dat=%h want 0/F/0", we, sel, dat_o); end
      step(); step();
      rst = 1'b0;
      step(); step(); step();
      checks++; if (stb !== 1'b0 || cyc !== 1'b0) begin errors++; $display("FAIL reset_idle got stb=%b cyc=%b want 0", stb, cyc); end
   endtask

   task automatic test_stream_watermark();
      int word;
      int exp_pix;
      bit ok;
      ack_en = 1'b1;
      start_frame(32'h1000);
      for (int i = 0; i < 8; i++) begin
         checks++; if (stb !== 1'b1 || adr !== 32'(32'h1000 + 4*i)) begin errors++; $display("FAIL fill_adr[%0d] got stb=%b adr=%h want stb=1 adr=%h", i, stb, adr, 32'h1000 + 4*i); end
         step();
      end
      checks++; if (stb !== 1'b0) begin errors++; $display("FAIL full_pause got stb=%b want 0", stb); end
      checks++; if (pix_valid !== 1'b1 || pix !== 8'h00) begin errors++; $display("FAIL full_head got valid=%b pix=%h want 1/00", pix_valid, pix); end
      step(); step(); step();
      checks++; if (stb !== 1'b0) begin errors++; $display("FAIL pause_hold got stb=%b want 0", stb); end
      for (int n = 0; n < 24; n++) begin
         pix_rd = 1'b1;
         checks++; if (pix !== 8'(n) || stb !== 1'b0) begin errors++; $display("FAIL drain_pix[%0d] got pix=%h stb=%b want pix=%h stb=0", n, pix, stb, 8'(n)); end
         step();
      end
      pix_rd = 1'b0;
      checks++; if (stb !== 1'b0) begin errors++; $display("FAIL wm_edge got stb=%b want 0", stb); end
      step();
      checks++; if (stb !== 1'b1 || adr !== 32'h1020) begin errors++; $display("FAIL wm_refill got stb=%b adr=%h want 1/00001020", stb, adr); end
      word = 8; exp_pix = 24; ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (exp_pix == 64 && !cyc && !pix_valid) begin ok = 1'b1; break; end
         if (stb) begin
            checks++; if (adr !== 32'(32'h1000 + 4*word)) begin errors++; $display("FAIL stream_adr[%0d] got %h want %h", word, adr, 32'h1000 + 4*word); end
            word++;
         end
         if (pix_valid) begin
            checks++; if (pix !== exp_pix[7:0]) begin errors++; $display("FAIL stream_pix[%0d] got %h want %h", exp_pix, pix, exp_pix[7:0]); end
         end
         pix_rd = pix_valid;
         step();
         if (pix_rd) exp_pix++;
      end
      pix_rd = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL stream_timeout got pixels=%0d want 64", exp_pix); end
      checks++; if (word != 16) begin errors++; $display("FAIL stream_words got %0d want 16", word); end
      checks++; if (cyc !== 1'b0 || underrun !== 1'b0 || err !== 1'b0 || pix !== 8'h00) begin errors++; $display("FAIL done_state got cyc=%b und=%b err=%b pix=%h want 0/0/0/00", cyc, underrun, err, pix); end
   endtask

   task automatic test_retry();
      ack_en = 1'b0;
      rty_en = 1'b1;
      start_frame(32'h2000);
      for (int i = 0; i < 3; i++) begin
         checks++; if (stb !== 1'b1 || adr !== 32'h2000 || err !== 1'b0) begin errors++; $display("FAIL rty3[%0d] got stb=%b adr=%h err=%b want 1/00002000/0", i, stb, adr, err); end
         step();
      end
      rty_en = 1'b0;
      ack_en = 1'b1;
      checks++; if (stb !== 1'b1 || adr !== 32'h2000) begin errors++; $display("FAIL rty_ack got stb=%b adr=%h want 1/00002000", stb, adr); end
      step();
      ack_en = 1'b0;
      checks++; if (stb !== 1'b1 || adr !== 32'h2004 || err !== 1'b0) begin errors++; $display("FAIL rty_next got stb=%b adr=%h err=%b want 1/00002004/0", stb, adr, err); end
      rty_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (stb !== 1'b1 || adr !== 32'h2004) begin errors++; $display("FAIL rty4[%0d] got stb=%b adr=%h want 1/00002004", i, stb, adr); end
         step();
      end
      rty_en = 1'b0;
      checks++; if (err !== 1'b1 || cyc !== 1'b0 || stb !== 1'b0) begin errors++; $display("FAIL rty_err got err=%b cyc=%b stb=%b want 1/0/0", err, cyc, stb); end
      checks++; if (pix_valid !== 1'b1 || pix !== 8'h00) begin errors++; $display("FAIL rty_data got valid=%b pix=%h want 1/00", pix_valid, pix); end
   endtask

   task automatic test_bus_err();
      start_frame(32'h2100);
      checks++; if (err !== 1'b0 || stb !== 1'b1 || pix_valid !== 1'b0) begin errors++; $display("FAIL berr_restart got err=%b stb=%b valid=%b want 0/1/0", err, stb, pix_valid); end
      err_en = 1'b1;
      ack_en = 1'b1;
      step();
      err_en = 1'b0;
      checks++; if (err !== 1'b1 || stb !== 1'b0 || pix_valid !== 1'b0) begin errors++; $display("FAIL berr_halt got err=%b stb=%b valid=%b want 1/0/0", err, stb, pix_valid); end
      step(); step();
      checks++; if (stb !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL berr_stay got stb=%b err=%b want 0/1", stb, err); end
      ack_en = 1'b0;
   endtask

   task automatic test_underrun();
      pix_rd = 1'b1;
      checks++; if (pix !== 8'h00 || pix_valid !== 1'b0) begin errors++; $display("FAIL und_empty got pix=%h valid=%b want 00/0", pix, pix_valid); end
      step();
      pix_rd = 1'b0;
      checks++; if (underrun !== 1'b1 || pix !== 8'h00) begin errors++; $display("FAIL und_set got und=%b pix=%h want 1/00", underrun, pix); end
      step(); step(); step();
      checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL und_sticky got %b want 1", underrun); end
      ack_en = 1'b1;
      start_frame(32'h3010);
      checks++; if (underrun !== 1'b0 || stb !== 1'b1 || adr !== 32'h3010 || pix_valid !== 1'b0) begin errors++; $display("FAIL und_clear got und=%b stb=%b adr=%h valid=%b want 0/1/00003010/0", underrun, stb, adr, pix_valid); end
      step();
      checks++; if (pix_valid !== 1'b1 || pix !== 8'h10 || adr !== 32'h3014) begin errors++; $display("FAIL und_refetch got valid=%b pix=%h adr=%h want 1/10/00003014", pix_valid, pix, adr); end
   endtask

   task automatic test_restart_ack();
      step(); step();
      checks++; if (stb !== 1'b1 || pix_valid !== 1'b1) begin errors++; $display("FAIL rs_pre got stb=%b valid=%b want 1/1", stb, pix_valid); end
      base_adr    = 32'h4040;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      checks++; if (pix_valid !== 1'b0 || stb !== 1'b1 || adr !== 32'h4040) begin errors++; $display("FAIL rs_flush got valid=%b stb=%b adr=%h want 0/1/00004040", pix_valid, stb, adr); end
      step();
      checks++; if (pix_valid !== 1'b1 || pix !== 8'h40) begin errors++; $display("FAIL rs_data got valid=%b pix=%h want 1/40", pix_valid, pix); end
   endtask

   task automatic test_reset_mid_fetch();
      checks++; if (stb !== 1'b1) begin errors++; $display("FAIL rmf_pre got stb=%b want 1", stb); end
      #2 rst = 1'b1;
      #1;
      checks++; if (cyc !== 1'b0 || stb !== 1'b0 || pix_valid !== 1'b0) begin errors++; $display("FAIL rmf_drop got cyc=%b stb=%b valid=%b want 0/0/0", cyc, stb, pix_valid); end
      step();
      rst = 1'b0;
      ack_en = 1'b0;
      step(); step(); step();
      checks++; if (stb !== 1'b0 || pix_valid !== 1'b0) begin errors++; $display("FAIL rmf_idle got stb=%b valid=%b want 0/0", stb, pix_valid); end
      start_frame(32'h5000);
      checks++; if (stb !== 1'b1 || adr !== 32'h5000) begin errors++; $display("FAIL rmf_start got stb=%b adr=%h want 1/00005000", stb, adr); end
   endtask

   initial begin
      test_reset();
      test_stream_watermark();
      test_retry();
      test_bus_err();
      test_underrun();
      test_restart_ack();
      test_reset_mid_fetch();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
